// File: rtl/prefix_scan_engine.sv
// prefix_scan_engine: sequential inclusive prefix scan over an internal array A.
// Each step writes the running result into array B. The operator is selectable:
// ADD (wrapping), unsigned MAX, or XOR. Mode 11 behaves as ADD.
// The final value is presented on return_val, together with a one-cycle done pulse.
// Optional feature macro: SCAN_OVF_EN adds a sticky ADD carry-out flag on port ovf.
module prefix_scan_engine #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   n,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] return_val,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [ADDR_W-1:0] b_raddr,
`ifdef SCAN_OVF_EN
    output logic              ovf,
`endif
    output logic [DATA_W-1:0] b_rdata
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] return_val_q, return_val_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] result_s;
    logic [ADDR_W:0]   n_clamp_s;
    logic              last_s;
    logic              a_wr_en_s;
    logic              b_wr_en_s;

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];

`ifdef SCAN_OVF_EN
    logic              ovf_q, ovf_d;
    logic [DATA_W:0]   sum_s;
`endif

    // Scan operator; identity is zero for every mode, so acc starts at 0.
    function automatic logic [DATA_W-1:0] op_apply(input logic [1:0] op,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] r;
        case (op)
            2'b00:   r = x + y;
            2'b01:   r = (x > y) ? x : y;
            2'b10:   r = x ^ y;
            2'b11:   r = x + y;
            default: r = x + y;
        endcase
        return r;
    endfunction

    assign n_clamp_s = (n > DEPTH_N) ? DEPTH_N : n;
    assign last_s    = ({1'b0, i_q} == (n_q - (ADDR_W+1)'(1)));
    assign result_s  = op_apply(mode_q, acc_q, operand_q);
    assign a_wr_en_s = a_we && (state_q == ST_IDLE);
    assign b_wr_en_s = (state_q == ST_ACC);

    // Control and output registers; async reset brings everything to idle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            mode_q       <= 2'b00;
            acc_q        <= '0;
            operand_q    <= '0;
            i_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            return_val_q <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            operand_q    <= operand_d;
            i_q          <= i_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            return_val_q <= return_val_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is ignored mid-run and in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_clamp_s == '0) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_ACC;
            ST_ACC: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; done/busy are registered, so done lands one edge after DONE.
    always_comb begin
        n_d          = n_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        operand_d    = operand_q;
        i_d          = i_q;
        return_val_d = return_val_q;
        b_rdata_d    = b_mem[b_raddr];
        done_d       = (state_q == ST_DONE);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_ACC);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d    = n_clamp_s;
                    mode_d = mode;
                    acc_d  = '0;
                    i_d    = '0;
                end else begin
                    n_d    = n_q;
                end
            end
            ST_LOAD: operand_d = a_mem[i_q];
            ST_ACC: begin
                acc_d = result_s;
                if (!last_s) begin
                    i_d = i_q + ADDR_W'(1);
                end else begin
                    i_d = i_q;
                end
            end
            ST_DONE: return_val_d = acc_q;
            default: acc_d = acc_q;
        endcase
    end

`ifdef SCAN_OVF_EN
    assign sum_s = {1'b0, acc_q} + {1'b0, operand_q};

    // Sticky carry flag: cleared when a run is accepted, set by any ADD-mode carry-out.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == ST_IDLE) && start) begin
            ovf_d = 1'b0;
        end else if ((state_q == ST_ACC) && (mode_q != 2'b01) && (mode_q != 2'b10) && sum_s[DATA_W]) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Array storage is deliberately not reset; the FSM is IDLE under reset, so no writes occur then.
    always_ff @(posedge sys_clk) begin
        if (a_wr_en_s) begin
            a_mem[a_addr] <= a_wdata;
        end
        if (b_wr_en_s) begin
            b_mem[i_q] <= result_s;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign return_val = return_val_q;
    assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_prefix_scan_engine.sv
// Directed, table-driven bench for prefix_scan_engine, plus hand-written multi-cycle cases.
module tb_prefix_scan_engine;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [8:0]  n;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] return_val;
    logic        a_we;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [7:0]  b_raddr;
    logic [31:0] b_rdata;
`ifdef SCAN_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    prefix_scan_engine dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .n          (n),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .return_val (return_val),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .b_raddr    (b_raddr),
`ifdef SCAN_OVF_EN
        .ovf        (ovf),
`endif
        .b_rdata    (b_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]       n;
        logic [1:0]       mode;
        logic [3:0][31:0] a;
        logic [31:0]      exp_ret;
        logic [3:0][31:0] exp_b;
        int               exp_edges;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic write_a(input logic [7:0] addr, input logic [31:0] data);
        @(negedge sys_clk);
        a_we = 1'b1; a_addr = addr; a_wdata = data;
        @(negedge sys_clk);
        a_we = 1'b0;
    endtask

    task automatic read_b(input logic [7:0] addr, output logic [31:0] data);
        @(negedge sys_clk);
        b_raddr = addr;
        @(negedge sys_clk);
        data = b_rdata;
    endtask

    // Waits (bounded) for done; edges are counted from the edge that sampled start.
    task automatic wait_done(input int launch, output int edges, output int bcnt);
        edges = -1;
        bcnt  = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge sys_clk);
            if (done) begin
                edges = cyc - launch - 1;
                break;
            end
            bcnt += busy ? 1 : 0;
        end
    endtask

    task automatic run_scan(input logic [8:0] nn, input logic [1:0] md,
                            output int edges, output int bcnt);
        int launch;
        int b2;
        @(negedge sys_clk);
        start = 1'b1; n = nn; mode = md;
        launch = cyc;
        @(negedge sys_clk);
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        if (done) begin
            edges = cyc - launch - 1;
        end else begin
            wait_done(launch, edges, b2);
            bcnt += b2;
        end
    endtask

    initial begin
        int          e, bc, launch, dcnt;
        logic [31:0] rd;

        vecs[0] = '{n:9'd4, mode:2'b00, a:{32'd4, 32'd3, 32'd2, 32'd1}, exp_ret:32'd10,
                    exp_b:{32'd10, 32'd6, 32'd3, 32'd1}, exp_edges:9, exp_ovf:1'b0};
        vecs[1] = '{n:9'd4, mode:2'b01, a:{32'd7, 32'd2, 32'd9, 32'd5}, exp_ret:32'd9,
                    exp_b:{32'd9, 32'd9, 32'd9, 32'd5}, exp_edges:9, exp_ovf:1'b0};
        vecs[2] = '{n:9'd4, mode:2'b10, a:{32'd7, 32'd2, 32'd9, 32'd5}, exp_ret:32'd9,
                    exp_b:{32'd9, 32'd14, 32'd12, 32'd5}, exp_edges:9, exp_ovf:1'b0};
        vecs[3] = '{n:9'd2, mode:2'b00, a:{32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, exp_ret:32'd1,
                    exp_b:{32'd9, 32'd14, 32'd1, 32'hFFFF_FFFF}, exp_edges:5, exp_ovf:1'b1};
        vecs[4] = '{n:9'd3, mode:2'b11, a:{32'd40, 32'd30, 32'd20, 32'd10}, exp_ret:32'd60,
                    exp_b:{32'd9, 32'd60, 32'd30, 32'd10}, exp_edges:7, exp_ovf:1'b0};
        vecs[5] = '{n:9'd1, mode:2'b01, a:{32'd0, 32'd0, 32'd0, 32'd7}, exp_ret:32'd7,
                    exp_b:{32'd9, 32'd60, 32'd30, 32'd7}, exp_edges:3, exp_ovf:1'b0};

        sys_rst_n = 1'b0; start = 1'b0; n = 9'd0; mode = 2'b00;
        a_we = 1'b0; a_addr = 8'd0; a_wdata = 32'd0; b_raddr = 8'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_return_val", return_val, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        sys_rst_n = 1'b1;

        // Table-driven runs; B[n..3] entries must keep the previous vector's values.
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 4; j++) write_a(8'(j), vecs[v].a[j]);
            run_scan(vecs[v].n, vecs[v].mode, e, bc);
            check($sformatf("vec%0d_edges", v), 32'(e), 32'(vecs[v].exp_edges));
            check($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'(2 * int'(vecs[v].n)));
            check($sformatf("vec%0d_return_val", v), return_val, vecs[v].exp_ret);
`ifdef SCAN_OVF_EN
            check($sformatf("vec%0d_ovf", v), {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
`endif
            for (int j = 0; j < 4; j++) begin
                read_b(8'(j), rd);
                check($sformatf("vec%0d_b%0d", v, j), rd, vecs[v].exp_b[j]);
            end
        end

        // n = 0: done one edge after start, return_val 0, B untouched.
        run_scan(9'd0, 2'b00, e, bc);
        check("n0_edges", 32'(e), 32'd1);
        check("n0_return_val", return_val, 32'd0);
        check("n0_busy_cycles", 32'(bc), 32'd0);
        read_b(8'd0, rd);
        check("n0_b0_unchanged", rd, 32'd7);

        // start pulse and A write during a run are both ignored.
        for (int j = 0; j < 4; j++) write_a(8'(j), 32'(j + 1));
        @(negedge sys_clk);
        start = 1'b1; n = 9'd4; mode = 2'b00;
        launch = cyc;
        @(negedge sys_clk);
        start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        start = 1'b1; n = 9'd1; a_we = 1'b1; a_addr = 8'd0; a_wdata = 32'd100;
        @(negedge sys_clk);
        start = 1'b0; a_we = 1'b0;
        wait_done(launch, e, bc);
        check("busy_ignore_edges", 32'(e), 32'd9);
        check("busy_ignore_return_val", return_val, 32'd10);
        run_scan(9'd1, 2'b00, e, bc);
        check("busy_ignore_a0_kept", return_val, 32'd1);

        // start held high through DONE launches exactly one more run.
        @(negedge sys_clk);
        start = 1'b1; n = 9'd2; mode = 2'b00;
        launch = cyc;
        wait_done(launch, e, bc);
        check("held_first_edges", 32'(e), 32'd5);
        check("held_first_return_val", return_val, 32'd3);
        check("held_busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge sys_clk);
        check("held_new_run_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge sys_clk);
            dcnt += done ? 1 : 0;
        end
        check("held_done_count", 32'(dcnt), 32'd1);
        check("held_second_return_val", return_val, 32'd3);

        // Reset during the third ACC of an n=8 run.
        for (int j = 0; j < 8; j++) write_a(8'(j), 32'(11 + j));
        @(negedge sys_clk);
        start = 1'b1; n = 9'd8; mode = 2'b00;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("midrun_busy_before", {31'd0, busy}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_done", {31'd0, done}, 32'd0);
        check("midrun_rst_return_val", return_val, 32'd0);
        check("midrun_rst_b_rdata", b_rdata, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        read_b(8'd0, rd);
        check("midrun_b0", rd, 32'd11);
        read_b(8'd1, rd);
        check("midrun_b1", rd, 32'd23);
        read_b(8'd2, rd);
        check("midrun_b2_old", rd, 32'd6);
        run_scan(9'd8, 2'b00, e, bc);
        check("after_rst_edges", 32'(e), 32'd17);
        check("after_rst_return_val", return_val, 32'd116);

        // n = DEPTH+1 clamps to DEPTH.
        for (int j = 0; j < 256; j++) write_a(8'(j), 32'(j + 1));
        run_scan(9'd257, 2'b00, e, bc);
        check("clamp_edges", 32'(e), 32'd513);
        check("clamp_busy_cycles", 32'(bc), 32'd512);
        check("clamp_return_val", return_val, 32'd32896);
        read_b(8'd255, rd);
        check("clamp_b255", rd, 32'd32896);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prefix_scan_engine.md
PREFIX_SCAN_ENGINE -- requirements
Module: prefix_scan_engine

Interface
REQ-001 DATA_W, 32, element and accumulator width in bits.
REQ-002 DEPTH, 256, entries in each of the internal arrays A and B; power of two, >= 2.
REQ-003 ADDR_W, log2(DEPTH), derived; not overridden.
REQ-004 sys_clk  in  1  clock; all state changes on the rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 n  in  ADDR_W+1  element count for the run.
REQ-008 mode  in  2  operator: 00 ADD, 01 MAX (unsigned), 10 XOR, 11 treated as ADD.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse at end of run.
REQ-011 return_val  out  DATA_W  final scan value B[n-1], held until the next run completes.
REQ-012 a_we / a_addr / a_wdata  in  1 / ADDR_W / DATA_W  host write port into A.
REQ-013 b_raddr  in  ADDR_W; b_rdata  out  DATA_W  host read port of B; registered, 1-cycle latency.

Function
REQ-014 States IDLE, LOAD, ACC, DONE; every transition occurs on a clock edge.
REQ-015 IDLE with start=1: latch n (clamped to DEPTH), latch mode, set acc=0 and i=0, go to LOAD; if the latched n is 0, go directly to DONE.
REQ-016 LOAD: read A[i] into the operand register; go to ACC.
REQ-017 ACC: r = op(acc, operand); acc<=r; B[i]<=r; if i==n-1 go to DONE, else i<=i+1 and go to LOAD.
REQ-018 DONE: done=1 for that cycle, return_val<=acc, go to IDLE.
REQ-019 Latency: done high in the cycle beginning 2n+1 edges after the edge that samples start; for n=0, 1 edge after.
REQ-020 ADD wraps modulo 2^DATA_W; MAX takes the unsigned compare; identity value is 0 for all modes.
REQ-021 start while busy is ignored; no queuing.
REQ-022 a_we while busy is dropped and A is unchanged; in IDLE, A[a_addr]<=a_wdata.
REQ-023 b_rdata is valid in all states; during a run it returns the current contents of B, which may be partially updated.
REQ-024 start in the same cycle as DONE is ignored; it is accepted in the following IDLE cycle.
REQ-025 Back-to-back runs reuse A unchanged; B entries at or above the new n keep their old values.

Reset
REQ-026 Assertion forces, immediately and asynchronously: state IDLE, busy=0, done=0, return_val=0, acc=0, i=0, b_rdata=0.
REQ-027 Arrays A and B are not cleared and have no file initialisation; contents after reset are unspecified for unwritten entries.
REQ-028 Reset mid-run aborts the run; B entries already written keep their values; no done pulse is generated.

Configuration
REQ-029 Macro SCAN_OVF_EN: when defined, add output ovf (1 bit); it clears when a run is accepted, sets sticky on any carry-out of an ADD-mode accumulation, and is valid with done and held until the next run is accepted; reset value 0.
REQ-030 Without SCAN_OVF_EN: port ovf is absent, no carry logic is present, and all other behaviour is identical.

Verification
REQ-031 Write A[0..3]={1,2,3,4}, start n=4 mode=00 -> done 9 edges after start; return_val=10; B[0..3]={1,3,6,10}; busy high for 8 cycles.
REQ-032 A[0..3]={5,9,2,7}, n=4, mode=01 -> B={5,9,9,9}, return_val=9; then mode=10 -> B={5,12,14,9}, return_val=9.
REQ-033 n=0 -> done 1 edge after start, return_val=0, B unchanged; n=DEPTH+1 -> clamped, done 2*DEPTH+1 edges after start.
REQ-034 A[0]=0xFFFFFFFF, A[1]=2, n=2, ADD -> return_val=1; with SCAN_OVF_EN ovf=1, without it the port is absent.
REQ-035 start pulse and a_we to A[0] during a run -> both ignored; result matches the original A; the same start held through DONE launches exactly one new run.
REQ-036 sys_rst_n low at the 3rd ACC of an n=8 run -> busy=0, done=0, return_val=0 immediately; B[0..1] hold new values; a new run then completes correctly.
